ps2_key_decoder: RTL

- Keyboard front end feeding the game state machine and the player-movement logic.
- Receives raw PS/2 frames and decodes set-2 make, break and extended (E0) sequences into per-key held levels and one-cycle press pulses.
- Drives enter_key_pressed, up_key_pressed and down_key_pressed, plus movement and bomb keys, in the main clk domain.

---
 rtl/ps2_pkg.sv | 50 +++++
 rtl/ps2_key_decoder_if.sv | 28 ++
 rtl/ps2_frame_rx.sv | 125 ++++++++++++
 rtl/ps2_key_decoder.sv | 83 ++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scancodes, key indices and receiver state type for the PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam int unsigned NUM_KEYS = 7;

  typedef enum logic [2:0] {
    KEY_ENTER = 3'd0,
    KEY_UP    = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_LEFT  = 3'd3,
    KEY_RIGHT = 3'd4,
    KEY_SPACE = 3'd5,
    KEY_ESC   = 3'd6
  } key_idx_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Arrows answer with or without E0 so the keypad 8/2/4/6 keys steer too.
  function automatic logic [NUM_KEYS-1:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] hit;
    hit = '0;
    case (code)
      SC_ENTER: hit[KEY_ENTER] = 1'b1;
      SC_UP:    hit[KEY_UP]    = 1'b1;
      SC_DOWN:  hit[KEY_DOWN]  = 1'b1;
      SC_LEFT:  hit[KEY_LEFT]  = 1'b1;
      SC_RIGHT: hit[KEY_RIGHT] = 1'b1;
      SC_SPACE: hit[KEY_SPACE] = ~ext;
      SC_ESC:   hit[KEY_ESC]   = ~ext;
      default:  hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Raw PS/2 lines in, decoded key levels/pulses and byte strobes out.
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  logic                ps2_clk;
  logic                ps2_data;
  logic [NUM_KEYS-1:0] keys_down;
  logic [NUM_KEYS-1:0] keys_pulse;
  logic                enter_key_pressed;
  logic                up_key_pressed;
  logic                down_key_pressed;
  logic [7:0]          last_code;
  logic                code_valid;
  logic                frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keys_down, keys_pulse, enter_key_pressed, up_key_pressed, down_key_pressed,
    input  last_code, code_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keys_down, keys_pulse, enter_key_pressed, up_key_pressed, down_key_pressed,
    output last_code, code_valid, frame_err
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, 11-bit frame FSM,
// odd-parity/stop check and a mid-frame watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2     // must be at least 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WD_MAX = WdW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  rx_state_t              state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   parity_q, parity_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic clk_s, data_s, fall, timeout;

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_s;
  assign timeout = (state_q != RX_IDLE) && (wd_q == WD_MAX);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    wd_d      = wd_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q == RX_IDLE) begin
      wd_d = '0;
    end else if (timeout) begin
      state_d = RX_IDLE;
      wd_d    = '0;
      err_d   = 1'b1;
    end else if (fall) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    // A timeout in the same cycle as an edge swallows the edge.
    if (fall && !timeout) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!data_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = data_s;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (data_s && (^{shift_q, parity_q})) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      wd_q        <= wd_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scancode decoder: E0/F0 prefix tracking, key map, held levels and press pulses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input logic              clk,
  input logic              reset,
  ps2_key_decoder_if.slave bus
);

  logic [7:0]          rx_byte;
  logic                byte_valid;
  logic                rx_err;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic [NUM_KEYS-1:0] keys_down_q, keys_down_d;
  logic [NUM_KEYS-1:0] keys_pulse_q, keys_pulse_d;
  logic [NUM_KEYS-1:0] hit;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (rx_err)
  );

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    keys_down_d  = keys_down_q;
    keys_pulse_d = '0;
    hit          = key_lookup(ext_q, rx_byte);
    if (byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          keys_down_d = keys_down_q & ~hit;
        end else begin
          keys_down_d  = keys_down_q | hit;
          // Typematic repeats of a held key give no fresh pulse.
          keys_pulse_d = hit & ~keys_down_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keys_down_q  <= '0;
      keys_pulse_q <= '0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keys_down_q  <= keys_down_d;
      keys_pulse_q <= keys_pulse_d;
    end
  end

  assign bus.keys_down         = keys_down_q;
  assign bus.keys_pulse        = keys_pulse_q;
  assign bus.enter_key_pressed = keys_down_q[KEY_ENTER];
  assign bus.up_key_pressed    = keys_down_q[KEY_UP];
  assign bus.down_key_pressed  = keys_down_q[KEY_DOWN];
  assign bus.last_code         = rx_byte;
  assign bus.code_valid        = byte_valid;
  assign bus.frame_err         = rx_err;

endmodule
